// File: rtl/prime_sweep_ctrl.sv
// prime_sweep_ctrl: sweeps candidates START..STOP onto the prime detector,
// holds each candidate for a settle window, samples the P/NP flags and
// streams primes over a valid/ready interface with a saturating count and a
// sticky consistency-error flag.
// Optional feature macro: PRIME_SWEEP_CHECKSUM_EN adds a 16-bit running sum
// of accepted primes on output prime_sum.
module prime_sweep_ctrl #(
  parameter logic [7:0]  START  = 8'd0,
  parameter logic [7:0]  STOP   = 8'd255,
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  cand,
  input  logic        det_p,
  input  logic        det_np,
  output logic        prime_valid,
  input  logic        prime_ready,
  output logic [7:0]  prime_data,
  output logic [7:0]  prime_count,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef PRIME_SWEEP_CHECKSUM_EN
  ,
  output logic [15:0] prime_sum
`endif
);

  localparam logic [3:0] P_SETTLE = 4'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_SAMPLE,
    S_EMIT,
    S_FIN
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cand, w_cand_nxt;
  logic [3:0]  r_wait, w_wait_nxt;
  logic        r_det_p, w_det_p_nxt;
  logic        r_det_np, w_det_np_nxt;
  logic        r_valid, w_valid_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic [7:0]  r_count, w_count_nxt;
  logic        r_busy;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic        w_advance;
`ifdef PRIME_SWEEP_CHECKSUM_EN
  logic [15:0] r_sum, w_sum_nxt;
`endif

  // Next-state and next-output logic; the detector flags are captured on the
  // edge that leaves HOLD so SAMPLE decides from stable registered values.
  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_wait_nxt   = r_wait;
    w_det_p_nxt  = r_det_p;
    w_det_np_nxt = r_det_np;
    w_valid_nxt  = r_valid;
    w_data_nxt   = r_data;
    w_count_nxt  = r_count;
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;
    w_advance    = 1'b0;
`ifdef PRIME_SWEEP_CHECKSUM_EN
    w_sum_nxt    = r_sum;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_HOLD;
          w_cand_nxt  = START;
          w_wait_nxt  = P_SETTLE;
          w_count_nxt = '0;
          w_err_nxt   = 1'b0;
`ifdef PRIME_SWEEP_CHECKSUM_EN
          w_sum_nxt   = '0;
`endif
        end
      end
      S_HOLD: begin
        if (r_wait == '0) begin
          w_state_nxt  = S_SAMPLE;
          w_det_p_nxt  = det_p;
          w_det_np_nxt = det_np;
        end else begin
          w_wait_nxt = r_wait - 4'd1;
        end
      end
      S_SAMPLE: begin
        if (r_det_p && !r_det_np) begin
          w_state_nxt = S_EMIT;
          w_data_nxt  = r_cand;
          w_valid_nxt = 1'b1;
        end else begin
          if (r_det_p == r_det_np) w_err_nxt = 1'b1;
          w_advance = 1'b1;
        end
      end
      S_EMIT: begin
        if (prime_ready) begin
          w_valid_nxt = 1'b0;
          if (r_count != '1) w_count_nxt = r_count + 8'd1;
`ifdef PRIME_SWEEP_CHECKSUM_EN
          w_sum_nxt   = r_sum + {8'd0, r_data};
`endif
          w_advance   = 1'b1;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // STOP is compared before incrementing, so cand never wraps past 255.
    if (w_advance) begin
      if (r_cand == STOP) begin
        w_state_nxt = S_FIN;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = S_HOLD;
        w_cand_nxt  = r_cand + 8'd1;
        w_wait_nxt  = P_SETTLE;
      end
    end
  end

  // State and output registers; reset overrides any sweep or handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cand   <= START;
      r_wait   <= '0;
      r_det_p  <= 1'b0;
      r_det_np <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef PRIME_SWEEP_CHECKSUM_EN
      r_sum    <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cand   <= w_cand_nxt;
      r_wait   <= w_wait_nxt;
      r_det_p  <= w_det_p_nxt;
      r_det_np <= w_det_np_nxt;
      r_valid  <= w_valid_nxt;
      r_data   <= w_data_nxt;
      r_count  <= w_count_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
`ifdef PRIME_SWEEP_CHECKSUM_EN
      r_sum    <= w_sum_nxt;
`endif
    end
  end

  assign cand        = r_cand;
  assign prime_valid = r_valid;
  assign prime_data  = r_data;
  assign prime_count = r_count;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
`ifdef PRIME_SWEEP_CHECKSUM_EN
  assign prime_sum   = r_sum;
`endif

endmodule

// File: tb/tb_prime_sweep_ctrl.sv
// Bench for prime_sweep_ctrl: a full-range instance (0..255, SETTLE=2) driven
// by an ideal detector model, and a single-candidate instance (7..7,
// SETTLE=3) used to pin down sampling latency. Expected primes come from
// trial division over the swept range.
module tb_prime_sweep_ctrl;

  localparam int BUD = 8000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        prime_ready = 1'b0;
  logic        det_p, det_np;
  logic [7:0]  cand, prime_data, prime_count;
  logic        prime_valid, busy, done, err;

  logic        start2 = 1'b0;
  logic        ready2 = 1'b0;
  logic        det_p2 = 1'b0;
  logic        det_np2 = 1'b1;
  logic [7:0]  cand2, data2, count2;
  logic        valid2, busy2, done2, err2;

`ifdef PRIME_SWEEP_CHECKSUM_EN
  logic [15:0] prime_sum, sum2;
`endif

  logic        inj_en = 1'b0;
  logic [7:0]  inj_val = 8'd0;

  int total = 0;
  int bad = 0;

  int acc_q[$];
  int model_q[$];
  int model_sum;
  int hold_viol = 0;
  int mono_viol = 0;

  always #5 clk = ~clk;

  function automatic logic is_prime(input int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d * d <= v; d++) if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Ideal detector for the main instance, with optional inconsistent-flag injection.
  always_comb begin
    det_p  = is_prime(int'(cand));
    det_np = !det_p;
    if (inj_en && cand == inj_val) begin
      det_p  = 1'b1;
      det_np = 1'b1;
    end
  end

  prime_sweep_ctrl #(.START(8'd0), .STOP(8'd255), .SETTLE(2)) u_dut (
    .clk(clk), .reset(reset), .start(start), .cand(cand),
    .det_p(det_p), .det_np(det_np),
    .prime_valid(prime_valid), .prime_ready(prime_ready),
    .prime_data(prime_data), .prime_count(prime_count),
    .busy(busy), .done(done), .err(err)
`ifdef PRIME_SWEEP_CHECKSUM_EN
    , .prime_sum(prime_sum)
`endif
  );

  prime_sweep_ctrl #(.START(8'd7), .STOP(8'd7), .SETTLE(3)) u_lat (
    .clk(clk), .reset(reset), .start(start2), .cand(cand2),
    .det_p(det_p2), .det_np(det_np2),
    .prime_valid(valid2), .prime_ready(ready2),
    .prime_data(data2), .prime_count(count2),
    .busy(busy2), .done(done2), .err(err2)
`ifdef PRIME_SWEEP_CHECKSUM_EN
    , .prime_sum(sum2)
`endif
  );

  // Handshake monitor: collects accepted primes, checks valid/data hold under
  // backpressure and that cand only steps by +1 while a sweep is running.
  logic       pv_prev = 1'b0, acc_prev = 1'b0, busy_prev = 1'b0;
  logic [7:0] pd_prev = 8'd0, cand_prev = 8'd0;
  always @(posedge clk) begin
    if (reset) begin
      pv_prev   = 1'b0;
      acc_prev  = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (prime_valid && prime_ready) acc_q.push_back(int'(prime_data));
      if (pv_prev && !acc_prev && (!prime_valid || prime_data != pd_prev)) hold_viol++;
      if (busy && busy_prev && cand != cand_prev && cand != cand_prev + 8'd1) mono_viol++;
      pv_prev   = prime_valid;
      acc_prev  = prime_valid && prime_ready;
      pd_prev   = prime_data;
      busy_prev = busy;
      cand_prev = cand;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cand"},  32'(cand), 32'd0);
    check({tag, "_valid"}, 32'(prime_valid), 32'd0);
    check({tag, "_data"},  32'(prime_data), 32'd0);
    check({tag, "_count"}, 32'(prime_count), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
`ifdef PRIME_SWEEP_CHECKSUM_EN
    check({tag, "_sum"},   32'(prime_sum), 32'd0);
`endif
  endtask

  function automatic int list_mismatch();
    int m = 0;
    if (acc_q.size() != model_q.size()) m++;
    for (int i = 0; i < acc_q.size() && i < model_q.size(); i++)
      if (acc_q[i] != model_q[i]) m++;
    return m;
  endfunction

  task automatic wait_done(input string tag, input logic rand_ready, input logic rand_start);
    int n = 0;
    while (!done && n < BUD) begin
      if (rand_ready) prime_ready = 1'($urandom_range(0, 1));
      if (rand_start) start = ($urandom_range(0, 5) == 0);
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, "_timeout"}, 32'(n < BUD), 32'd1);
  endtask

  initial begin
    int n;
    int first4 [4];
    logic seen10, err10;
    int stall_bad;

    model_sum = 0;
    for (int v = 0; v <= 255; v++)
      if (is_prime(v)) begin
        model_q.push_back(v);
        model_sum += v;
      end
    model_sum = model_sum & 32'hFFFF;

    // Reset state of both instances.
    repeat (3) tick();
    reset = 1'b0;
    check_reset("rst");
    check("rst_lat_cand", 32'(cand2), 32'd7);
    check("rst_lat_busy", 32'(busy2), 32'd0);

    // Full sweep, ready tied high.
    prime_ready = 1'b1;
    acc_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_cand0", 32'(cand), 32'd0);
    wait_done("t1", 1'b0, 1'b0);
    check("t1_count", 32'(prime_count), 32'(model_q.size()));
    check("t1_count54", 32'(prime_count), 32'd54);
    check("t1_err", 32'(err), 32'd0);
    check("t1_list", 32'(list_mismatch()), 32'd0);
    for (int i = 0; i < 4; i++) first4[i] = (i < acc_q.size()) ? acc_q[i] : -1;
    check("t1_p0", 32'(first4[0]), 32'd2);
    check("t1_p1", 32'(first4[1]), 32'd3);
    check("t1_p2", 32'(first4[2]), 32'd5);
    check("t1_p3", 32'(first4[3]), 32'd7);
    check("t1_last", 32'(acc_q.size() > 0 ? acc_q[acc_q.size() - 1] : -1), 32'd251);
`ifdef PRIME_SWEEP_CHECKSUM_EN
    check("t1_sum", 32'(prime_sum), 32'(model_sum));
`endif
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_count_hold", 32'(prime_count), 32'd54);

    // Backpressure on prime 2, then random ready, error at 9, stray starts.
    prime_ready = 1'b0;
    acc_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_count_clr", 32'(prime_count), 32'd0);
    n = 0;
    while (!prime_valid && n < BUD) begin tick(); n++; end
    check("t2_valid_to", 32'(n < BUD), 32'd1);
    check("t2_data", 32'(prime_data), 32'd2);
    check("t2_cand", 32'(cand), 32'd2);
    stall_bad = 0;
    repeat (4) begin
      tick();
      if (!prime_valid || prime_data != 8'd2 || cand != 8'd2 || prime_count != 8'd0) stall_bad++;
    end
    check("t2_stall", 32'(stall_bad), 32'd0);
    check("t2_count_pre", 32'(prime_count), 32'd0);
    prime_ready = 1'b1;
    tick();
    check("t2_valid_drop", 32'(prime_valid), 32'd0);
    check("t2_count_post", 32'(prime_count), 32'd1);

    inj_en  = 1'b1;
    inj_val = 8'd9;
    seen10  = 1'b0;
    err10   = 1'b0;
    n = 0;
    while (!done && n < BUD) begin
      prime_ready = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 5) == 0);
      tick();
      n++;
      if (cand == 8'd10 && !seen10) begin
        seen10 = 1'b1;
        err10  = err;
      end
    end
    check("t4_timeout", 32'(n < BUD), 32'd1);
    check("t4_err_at10", {30'd0, seen10, err10}, 32'd3);
    check("t4_err_sticky", 32'(err), 32'd1);
    check("t6_count", 32'(prime_count), 32'd54);
    check("t6_list", 32'(list_mismatch()), 32'd0);
    check("t6_hold", 32'(hold_viol), 32'd0);
    check("t6_mono", 32'(mono_viol), 32'd0);
`ifdef PRIME_SWEEP_CHECKSUM_EN
    check("t6_sum", 32'(prime_sum), 32'(model_sum));
`endif
    // start during the FIN cycle must not restart the sweep.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_fin_start", 32'(busy), 32'd0);
    tick();
    check("t6_fin_start2", 32'(busy), 32'd0);
    check("t6_err_hold", 32'(err), 32'd1);

    // Next start clears err; reset while valid is low at candidate 100.
    inj_en = 1'b0;
    prime_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_err_clr", 32'(err), 32'd0);
    n = 0;
    while (!(cand == 8'd100 && !prime_valid) && n < BUD) begin tick(); n++; end
    check("t5a_to", 32'(n < BUD), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset("t5a");

    // Reset while a prime (101) is pending.
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (cand != 8'd101 && n < BUD) begin tick(); n++; end
    prime_ready = 1'b0;
    while (!prime_valid && n < BUD) begin tick(); n++; end
    check("t5b_to", 32'(n < BUD), 32'd1);
    check("t5b_data", 32'(prime_data), 32'd101);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset("t5b");
    tick();
    check("t5b_stay_idle", 32'(busy), 32'd0);

    // Restart after reset sweeps from START with random backpressure.
    acc_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_restart_cand", 32'(cand), 32'd0);
    check("t5_restart_busy", 32'(busy), 32'd1);
    wait_done("t5_full", 1'b1, 1'b0);
    check("t5_list", 32'(list_mismatch()), 32'd0);
    check("t5_count", 32'(prime_count), 32'd54);
    check("t5_hold", 32'(hold_viol), 32'd0);
    prime_ready = 1'b1;
    tick();

    // Latency on the 7..7 instance: only the edge 4 cycles after cand=7 sees P.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("t3_busy", 32'(busy2), 32'd1);
    check("t3_cand", 32'(cand2), 32'd7);
    repeat (3) tick();
    det_p2 = 1'b1;
    det_np2 = 1'b0;
    tick();
    det_p2 = 1'b0;
    det_np2 = 1'b1;
    check("t3_valid_early", 32'(valid2), 32'd0);
    tick();
    check("t3_valid", 32'(valid2), 32'd1);
    check("t3_data", 32'(data2), 32'd7);
    tick();
    check("t3_valid_hold", 32'(valid2), 32'd1);
    check("t3_done_early", 32'(done2), 32'd0);
    ready2 = 1'b1;
    tick();
    ready2 = 1'b0;
    check("t3_done", 32'(done2), 32'd1);
    check("t3_valid_drop", 32'(valid2), 32'd0);
    check("t3_count", 32'(count2), 32'd1);
    check("t3_err", 32'(err2), 32'd0);
    tick();
    check("t3_done_one", 32'(done2), 32'd0);
    check("t3_idle", 32'(busy2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
